// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined two-operand adder/subtractor. The carry chain is cut into
//   CHUNK-bit slices and each register stage resolves one slice, so wide
//   operands close timing. Supports carry/borrow-in, carry-out, a signed
//   overflow flag and optional signed saturation (SAT=1).
//
//   Pipeline: an operand-prep register (index 0) captures A, the effective
//   B (inverted for subtract) and the effective carry-in. Stage k reads
//   register k, adds slice k and writes register k+1. Register NSTAGE holds
//   the final result, so a beat accepted at edge t is presented after edge
//   t+NSTAGE.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle when in_valid is high
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_sub     in   1      0 = A+B+cin, 1 = A-B-cin
//   in_cin     in   1      carry-in (add) / borrow-in (sub)
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer takes the result this cycle
//   out_sum    out  WIDTH  result (wrapped, or clamped when SAT=1)
//   out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//   out_ovf    out  1      signed overflow of the unsaturated result
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSTAGE = WIDTH / CHUNK;

  // Index 0 is the operand-prep register, index NSTAGE the output register.
  // The subtract flag is not carried: it is fully folded into b_q and c_q.
  logic [NSTAGE:0]  vld_q;
  logic [WIDTH-1:0] a_q   [NSTAGE+1];
  logic [WIDTH-1:0] b_q   [NSTAGE+1];
  logic [WIDTH-1:0] sum_q [NSTAGE+1];
  logic             c_q   [NSTAGE+1];

  logic [CHUNK:0]   slice [NSTAGE];
  logic [WIDTH-1:0] nsum  [NSTAGE];

  logic advance;
  logic a_msb, b_msb, s_msb, raw_ovf;
  logic [WIDTH-1:0] sat_val;

  assign advance  = !vld_q[NSTAGE] || out_ready;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      slice[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
               + (CHUNK+1)'(c_q[k]);
      nsum[k] = sum_q[k];
      nsum[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int j = 0; j <= NSTAGE; j++) begin
        a_q[j]   <= '0;
        b_q[j]   <= '0;
        sum_q[j] <= '0;
        c_q[j]   <= 1'b0;
      end
    end else if (advance) begin
      // Bubbles shift through like real beats; only vld_q marks them.
      vld_q[0] <= in_valid;
      a_q[0]   <= in_a;
      b_q[0]   <= in_sub ? ~in_b : in_b;
      c_q[0]   <= in_sub ^ in_cin;
      sum_q[0] <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        vld_q[k+1] <= vld_q[k];
        a_q[k+1]   <= a_q[k];
        b_q[k+1]   <= b_q[k];
        sum_q[k+1] <= nsum[k];
        c_q[k+1]   <= slice[k][CHUNK];
      end
    end
  end

  // Overflow from the registered MSBs of A, effective B and the raw sum.
  // A reset output register is all-zero, so the flag and sum read 0.
  assign a_msb   = a_q[NSTAGE][WIDTH-1];
  assign b_msb   = b_q[NSTAGE][WIDTH-1];
  assign s_msb   = sum_q[NSTAGE][WIDTH-1];
  assign raw_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  assign sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  assign out_valid = vld_q[NSTAGE];
  assign out_cout  = c_q[NSTAGE];
  assign out_ovf   = raw_ovf;
  assign out_sum   = (SAT && raw_ovf) ? sat_val : sum_q[NSTAGE];

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [W-1:0] ssum;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic         in_ready, out_valid, out_cout, out_ovf;
  logic [W-1:0] out_sum;
  logic         s_in_ready, s_out_valid, s_out_cout, s_out_ovf;
  logic [W-1:0] s_out_sum;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_addsub #(.WIDTH(W), .CHUNK(8), .SAT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_addsub #(.WIDTH(W), .CHUNK(8), .SAT(1'b1)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: 33-bit unsigned arithmetic for sum/carry and
  // 64-bit signed arithmetic for overflow and clamping.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, output exp_t e);
    logic [W:0] u;
    longint     s;
    if (!sub) begin
      u = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.cout = u[W];
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      u = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
      e.cout = ~u[W];
      s = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    e.sum  = u[W-1:0];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.ssum = e.ovf ? ((s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : e.sum;
  endtask

  task automatic run_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                          input logic [W-1:0] e_ssum);
    int lat;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    // Inputs change after acceptance; the accepted beat must not see it.
    in_a = '1; in_b = '1; in_sub = ~sub; in_cin = ~cin;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_sum"},     64'(out_sum),  64'(e_sum));
    check({tag, "_cout"},    64'(out_cout), 64'(e_cout));
    check({tag, "_ovf"},     64'(out_ovf),  64'(e_ovf));
    check({tag, "_sat_vld"}, 64'(s_out_valid), 64'd1);
    check({tag, "_sat_sum"}, 64'(s_out_sum), 64'(e_ssum));
    check({tag, "_sat_ovf"}, 64'(s_out_ovf), 64'(e_ovf));
    check({tag, "_sat_cout"}, 64'(s_out_cout), 64'(e_cout));
    tick();
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    exp_t         q[$];
    exp_t         e, got_e;
    logic [W-1:0] ra, rb;
    logic         rsub, rcin;
    bit           need_new;
    int           sent, got, cyc, seen;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    reset = 1'b0;
    tick();
    check("rst_in_ready",     64'(in_ready),   64'd1);
    check("rst_sat_in_ready", 64'(s_in_ready), 64'd1);

    // Directed vectors
    run_beat("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0100, 1'b0, 1'b0, 32'h0000_0100);
    run_beat("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
    run_beat("add_posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF);
    run_beat("sub_negovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
             32'h7FFF_FFFF, 1'b1, 1'b1, 32'h8000_0000);
    run_beat("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
             32'hFFFF_FFFD, 1'b0, 1'b0, 32'hFFFF_FFFD);
    run_beat("sub_plain",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0,
             32'h0000_0002, 1'b1, 1'b0, 32'h0000_0002);
    run_beat("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000);
    run_beat("add_cin",    32'h1234_5678, 32'h0000_FFFF, 1'b0, 1'b1,
             32'h1235_5678, 1'b0, 1'b0, 32'h1235_5678);

    // Random stream with random back-pressure
    sent = 0; got = 0; cyc = 0; need_new = 1'b1;
    ra = '0; rb = '0; rsub = 1'b0; rcin = 1'b0;
    while (got < 16 && cyc < 400) begin
      if (need_new && sent < 16) begin
        ra = $urandom; rb = $urandom;
        rsub = 1'($urandom_range(0, 1));
        rcin = 1'($urandom_range(0, 1));
        need_new = 1'b0;
      end
      in_valid = (sent < 16);
      in_a = ra; in_b = rb; in_sub = rsub; in_cin = rcin;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        model(ra, rb, rsub, rcin, e);
        q.push_back(e);
        sent++;
        need_new = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_extra_beat", 64'd1, 64'd0);
        end else begin
          got_e = q.pop_front();
          check("stream_sum",     64'(out_sum),   64'(got_e.sum));
          check("stream_cout",    64'(out_cout),  64'(got_e.cout));
          check("stream_ovf",     64'(out_ovf),   64'(got_e.ovf));
          check("stream_sat_sum", 64'(s_out_sum), 64'(got_e.ssum));
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count",   64'(got), 64'd16);
    check("stream_pending", 64'(q.size()), 64'd0);
    repeat (6) tick();
    check("stream_no_dup", 64'(out_valid), 64'd0);

    // Reset with beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'h0000_1000 + 32'(i); in_b = 32'h0000_0010;
      in_sub = 1'b0; in_cin = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("flight_out_valid", 64'(out_valid), 64'd1);
    check("flight_stalled",   64'(in_ready),  64'd0);
    check("flight_head_sum",  64'(out_sum),   64'h0000_1011);
    reset = 1'b1;
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_sum",   64'(out_sum),   64'd0);
    check("midrst_out_cout",  64'(out_cout),  64'd0);
    check("midrst_out_ovf",   64'(out_ovf),   64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid || s_out_valid) seen++;
    end
    check("midrst_no_ghost", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
